// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
//
// Shares the single 64-bit, 32-entry register-file read mux among N_REQ
// requesters. Each cycle at most one valid request is granted in round-robin
// order starting at the priority pointer. The granted register number is
// registered onto rf_sel. One edge later the mux output is captured and
// returned as rsp_data, tagged with the requester index on rsp_id. Register 31
// reads as zero (XZR).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_valid  in   [N_REQ]    per-requester read request
//   req_addr   in   [5*N_REQ]  register number of requester i in [5i+4:5i]
//   req_ready  out  [N_REQ]    one-hot combinational grant
//   stall      in   blocks new grants while high
//   rf_sel     out  [5]        registered select for the read mux
//   rf_data    in   [64]       combinational read-mux output for rf_sel
//   rsp_valid  out  one-cycle response pulse
//   rsp_id     out  [ID_W]     requester index of the response
//   rsp_data   out  [64]       read data, zero for register 31
// -----------------------------------------------------------------------------
module regfile_read_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [5*N_REQ-1:0]   req_addr,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 stall,
    output logic [4:0]           rf_sel,
    input  logic [63:0]          rf_data,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [63:0]          rsp_data
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [4:0]      rf_sel_q, rf_sel_d;
    logic            s1_valid_q, s1_valid_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s1_zero_q, s1_zero_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [63:0]     rsp_data_q, rsp_data_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic [4:0]      grant_addr;
    logic            xfer;

    // Round-robin search. Offsets are scanned from the far end back towards
    // the pointer so the candidate closest to ptr is the last one written and
    // therefore wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Select the winner's register number from the packed address bus.
    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_addr = req_addr[5*i +: 5];
            end
        end
    end

    // Grant is suppressed by stall and by reset so nothing transfers while
    // the pipeline is being cleared.
    always_comb begin
        xfer      = grant_found & ~stall & ~reset;
        req_ready = '0;
        if (xfer) begin
            req_ready = N_REQ'(1) << grant_idx;
        end
    end

    // Next-state for the select/stage-1 registers and the pointer. On a
    // transfer the pointer moves just past the winner; otherwise everything
    // except s1_valid holds.
    always_comb begin
        ptr_d      = ptr_q;
        rf_sel_d   = rf_sel_q;
        s1_valid_d = xfer;
        s1_id_d    = s1_id_q;
        s1_zero_d  = s1_zero_q;
        if (xfer) begin
            rf_sel_d  = grant_addr;
            s1_id_d   = grant_idx;
            s1_zero_d = (grant_addr == 5'd31);
            if (grant_idx == ID_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // Response stage: the mux output for rf_sel is captured one edge after
    // the grant. Id and data hold between responses.
    always_comb begin
        rsp_valid_d = s1_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (s1_valid_q) begin
            rsp_id_d   = s1_id_q;
            rsp_data_d = s1_zero_q ? 64'd0 : rf_data;
        end
    end

    // Asynchronous reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            rf_sel_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_zero_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rf_sel_q    <= rf_sel_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_zero_q   <= s1_zero_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rf_sel    = rf_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_arbiter
//
// Self-checking bench for regfile_read_arbiter with N_REQ=4. A behavioural
// model tracks the round-robin pointer as a plain integer and keeps a queue of
// expected responses stamped with the cycle they are due; the register file is
// an array driven back into rf_data.
// -----------------------------------------------------------------------------
module tb_regfile_read_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    typedef struct {
        int          due;
        int          id;
        logic [63:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [5*N-1:0] req_addr = '0;
    logic [N-1:0]  req_ready;
    logic          stall = 1'b0;
    logic [4:0]    rf_sel;
    logic [63:0]   rf_data;
    logic          rsp_valid;
    logic [W-1:0]  rsp_id;
    logic [63:0]   rsp_data;

    logic [63:0]   rfMem [32];

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            mPtr = 0;
    rsp_t          expQ [$];
    logic          expRspValid = 1'b0;
    int            mLastId = 0;
    logic [63:0]   mLastData = '0;
    logic [4:0]    expRfSel = '0;

    regfile_read_arbiter #(.N_REQ(N), .ID_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .stall     (stall),
        .rf_sel    (rf_sel),
        .rf_data   (rf_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    assign rf_data = rfMem[rf_sel];

    always #5 clk = ~clk;

    // First valid requester at or after the pointer, or -1.
    function automatic int findWinner();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(mPtr + k) % N]) return (mPtr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] expReadyFn();
        int g;
        g = findWinner();
        if (reset || stall || g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic setAddr(input int i, input int a);
        req_addr[5*i +: 5] = 5'(a);
    endtask

    task automatic modelReset();
        mPtr = 0;
        expQ.delete();
        expRspValid = 1'b0;
        mLastId = 0;
        mLastData = '0;
        expRfSel = '0;
    endtask

    // Advance one clock edge and update the model; returns at edge + 1.
    task automatic tick();
        int   g;
        int   a;
        logic xfer;
        g = findWinner();
        xfer = (expReadyFn() != '0);
        a = 0;
        if (xfer) a = int'(req_addr[5*g +: 5]);
        @(posedge clk);
        cyc++;
        if (!reset) begin
            if (xfer) begin
                expQ.push_back('{cyc + 1, g, (a == 31) ? 64'd0 : rfMem[a]});
                mPtr = (g + 1) % N;
                expRfSel = 5'(a);
            end
            if (expQ.size() > 0 && expQ[0].due == cyc) begin
                expRspValid = 1'b1;
                mLastId = expQ[0].id;
                mLastData = expQ[0].data;
                void'(expQ.pop_front());
            end else begin
                expRspValid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) setAddr(i, 7 + i);
        repeat (3) tick();
        @(negedge clk);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        total++;
        if ({req_ready, rf_sel, rsp_valid, rsp_id, rsp_data} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_async ready=%b sel=%0d rv=%b id=%0d data=%h required all zero",
                     req_ready, rf_sel, rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b0001;
        setAddr(0, 5);
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL reset_first_ready got=%b required=0001", req_ready);
        end
        tick();
        req_valid = '0;
        total++;
        if (rf_sel !== 5'd5) begin
            bad++;
            $display("[TB] FAIL reset_rf_sel got=%0d required=5", rf_sel);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== rfMem[5]) begin
            bad++;
            $display("[TB] FAIL reset_rsp got v=%b id=%0d data=%h required v=1 id=0 data=%h",
                     rsp_valid, rsp_id, rsp_data, rfMem[5]);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        applyReset();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) setAddr(i, i + 1);
        for (int k = 0; k < 8; k++) begin
            #1;
            want = N'(1) << (k % N);
            total++;
            if (req_ready !== want) begin
                bad++;
                $display("[TB] FAIL rr_ready step=%0d got=%b required=%b", k, req_ready, want);
            end
            tick();
            total++;
            if (rf_sel !== 5'((k % N) + 1)) begin
                bad++;
                $display("[TB] FAIL rr_sel step=%0d got=%0d required=%0d", k, rf_sel, (k % N) + 1);
            end
            if (k >= 1) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % N) ||
                    rsp_data !== rfMem[((k - 1) % N) + 1]) begin
                    bad++;
                    $display("[TB] FAIL rr_rsp step=%0d got v=%b id=%0d data=%h required id=%0d data=%h",
                             k, rsp_valid, rsp_id, rsp_data, (k - 1) % N, rfMem[((k - 1) % N) + 1]);
                end
            end
        end
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_wrap_skip();
        applyReset();
        req_valid = 4'b0100;
        setAddr(0, 11);
        setAddr(2, 12);
        tick();
        req_valid = 4'b0101;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL wrap_first got=%b required=0001", req_ready);
        end
        tick();
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL wrap_second got=%b required=0100", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_xzr();
        rfMem[31] = '1;
        req_valid = 4'b0010;
        setAddr(1, 31);
        tick();
        req_valid = '0;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'd0 || rsp_id !== 2'd1) begin
            bad++;
            $display("[TB] FAIL xzr got v=%b id=%0d data=%h required v=1 id=1 data=0",
                     rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_stall();
        applyReset();
        req_valid = 4'b0010;
        setAddr(0, 3);
        setAddr(1, 6);
        tick();
        req_valid = 4'b0011;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL stall_ready step=%0d got=%b required=0000", k, req_ready);
            end
            tick();
            if (k == 0) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== rfMem[6]) begin
                    bad++;
                    $display("[TB] FAIL stall_inflight got v=%b id=%0d data=%h required v=1 id=1 data=%h",
                             rsp_valid, rsp_id, rsp_data, rfMem[6]);
                end
            end else begin
                total++;
                if (rsp_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL stall_norsp step=%0d got v=%b required 0", k, rsp_valid);
                end
            end
        end
        stall = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL stall_release got=%b required=0001", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_reset_midflight();
        applyReset();
        req_valid = 4'b0100;
        setAddr(2, 9);
        tick();
        req_valid = '0;
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midflight_async got v=%b required 0", rsp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midflight_norsp step=%0d got v=%b required 0", k, rsp_valid);
            end
        end
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL midflight_ptr got=%b required=0001", req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            req_addr = 20'($urandom);
            stall = ($urandom_range(0, 4) == 0);
            #1;
            total++;
            if (req_ready !== expReadyFn()) begin
                bad++;
                $display("[TB] FAIL rand_ready cyc=%0d got=%b required=%b", cyc, req_ready, expReadyFn());
            end
            tick();
            total++;
            if (rf_sel !== expRfSel || rsp_valid !== expRspValid ||
                rsp_id !== 2'(mLastId) || rsp_data !== mLastData) begin
                bad++;
                $display("[TB] FAIL rand_out cyc=%0d got sel=%0d v=%b id=%0d data=%h required sel=%0d v=%b id=%0d data=%h",
                         cyc, rf_sel, rsp_valid, rsp_id, rsp_data,
                         expRfSel, expRspValid, mLastId, mLastData);
            end
        end
        req_valid = '0;
        stall = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rfMem[i] = {$urandom, $urandom};
        modelReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_xzr();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Round-robin arbiter that shares the single 64-bit, 32-entry register-file read mux among several requesters (decode-stage read ports, debug/trace reader). Each cycle it grants at most one valid request and drives the mux select lines from a register. One cycle later it captures the selected 64-bit word and returns it tagged with the requester ID. It sits between the pipeline's operand-fetch requesters and the register-file read mux.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID; must equal clog2(N_REQ)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester read request
- req_addr  in  5*N_REQ  register number for requester i in bits [5i+4:5i]
- req_ready  out  N_REQ  one-hot grant; a request transfers when req_valid[i] & req_ready[i]
- stall  in  1  when high, no new request is granted
- rf_sel  out  5  registered select to read mux; bit 4..0 = S4..S0
- rf_data  in  64  combinational read-mux output for rf_sel
- rsp_valid  out  1  response valid, one-cycle pulse, no backpressure
- rsp_id  out  ID_W  requester index of the response
- rsp_data  out  64  read data; X31 forced to 0

## Operation
- Priority pointer ptr (ID_W bits), reset 0.
- Grant search order: ptr, ptr+1, …, ptr+N_REQ-1 (mod N_REQ). The first i with req_valid[i]=1 wins.
- req_ready is combinational.
  - req_ready[g]=1 only for the winner g, and only when stall=0 and reset=0.
  - req_ready is all-zero when no request is valid.
- On a transfer at edge E0:
  - rf_sel <= req_addr[g].
  - s1_valid <= 1, s1_id <= g, s1_zero <= (req_addr[g]==31).
  - ptr <= g+1 mod N_REQ. The wrap from N_REQ-1 goes to 0.
- With no transfer: s1_valid <= 0, and rf_sel and ptr hold.
- Response stage, at the edge after a transfer:
  - rsp_valid <= s1_valid, rsp_id <= s1_id.
  - rsp_data <= s1_zero ? 0 : rf_data.
  - When s1_valid=0: rsp_valid <= 0, and rsp_data and rsp_id hold.
- Requester behaviour: must hold req_valid and req_addr until it sees ready. It may drop req_valid at any time before grant with no side effects.
- stall:
  - Blocks new grants only. An in-flight s1 entry still produces its response.
  - ptr does not move while stalled.
- Reset (asynchronous, any time):
  - rf_sel=0, s1_valid=0, s1_id=0, s1_zero=0, ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - An in-flight request is dropped and gets no response. Requesters must reissue.

## Timing
- Throughput: one grant per cycle while any request is valid and stall=0.
- Latency: a transfer at edge E0 gives rf_sel valid just after E0 and rsp_valid=1 during the cycle after E1. That is 2 edges from acceptance to registered response.
- The read mux path (rf_sel register → mux → rsp_data register) is the critical path and must fit in one cycle.
- Fairness: a continuously valid requester is granted within N_REQ grants.
- Back-to-back grants to different requesters give back-to-back rsp_valid pulses in grant order.
- rsp_valid is never high for 2 cycles with the same grant.
- Simultaneous events:
  - stall rising in the same cycle as a valid request: no grant.
  - Reset deasserting: the first grant is possible at the first edge after deassertion, with ptr=0.

## Test plan
- Reset values: assert reset mid-cycle with requests pending. Required: all outputs 0 immediately (asynchronous), req_ready=0. After release with req_valid=4'b0001 and addr0=5, req_ready=4'b0001, rf_sel=5 after the next edge, and rsp_data=R5 with rsp_id=0 one edge later.
- Round-robin: req_valid=4'b1111 held, addresses 1,2,3,4, ptr=0. Required: grants 0,1,2,3,0,… on consecutive edges, rsp_id sequence 0,1,2,3 with rsp_data R1..R4, one response per cycle.
- Wrap/skip: ptr=3 after granting 2, with req_valid=4'b0101. Required: next grant 0 (wraps past absent 3), then 2.
- XZR: request addr 31 while the mux returns 64'hFFFF_FFFF_FFFF_FFFF. Required: rsp_data=0, rsp_valid=1.
- Stall: grant req1 at E0, stall=1 from E0 to E3 with req_valid=4'b0011. Required: the response for req1 still appears after E1, no req_ready during stall, ptr stays 2. The first grant after stall deasserts is req0 (wrap from 2 past absent 2,3 → 0).
- Reset mid-flight: grant at E0, assert reset before E1. Required: no rsp_valid for that request, ptr=0 after release.
